// File: rtl/mastermind_scorer_if.sv
// -----------------------------------------------------------------------------
// mastermind_scorer_if
// Bundles the game-control, guess and score signals of mastermind_scorer.
//   iNEW_GAME, iSECRET0..3      : new-game strobe and secret colours
//   iGUESS_VALID, iGUESS0..3    : guess offer and guess colours
//   oREADY                      : scorer idle with a game active
//   oSCORE_VALID                : one-cycle pulse, score outputs just updated
//   oRVALUE01..04               : last scored guess, positions 0..3
//   oBlackPegs, oWhitePegs      : peg counts of the last score
//   oNrOfRows                   : guesses scored this game
//   oWIN, oLOSE                 : sticky game result flags
//   oREJECT                     : invalid-guess pulse (optional feature)
// Modports: master drives the inputs (game controller / bench),
//           slave is the scorer itself.
// -----------------------------------------------------------------------------
interface mastermind_scorer_if;
  logic       iNEW_GAME;
  logic [2:0] iSECRET0;
  logic [2:0] iSECRET1;
  logic [2:0] iSECRET2;
  logic [2:0] iSECRET3;
  logic       iGUESS_VALID;
  logic [2:0] iGUESS0;
  logic [2:0] iGUESS1;
  logic [2:0] iGUESS2;
  logic [2:0] iGUESS3;
  logic       oREADY;
  logic       oSCORE_VALID;
  logic [2:0] oRVALUE01;
  logic [2:0] oRVALUE02;
  logic [2:0] oRVALUE03;
  logic [2:0] oRVALUE04;
  logic [2:0] oBlackPegs;
  logic [2:0] oWhitePegs;
  logic [2:0] oNrOfRows;
  logic       oWIN;
  logic       oLOSE;
  logic       oREJECT;

  modport master (
    output iNEW_GAME, iSECRET0, iSECRET1, iSECRET2, iSECRET3,
    output iGUESS_VALID, iGUESS0, iGUESS1, iGUESS2, iGUESS3,
    input  oREADY, oSCORE_VALID, oRVALUE01, oRVALUE02, oRVALUE03, oRVALUE04,
    input  oBlackPegs, oWhitePegs, oNrOfRows, oWIN, oLOSE, oREJECT
  );

  modport slave (
    input  iNEW_GAME, iSECRET0, iSECRET1, iSECRET2, iSECRET3,
    input  iGUESS_VALID, iGUESS0, iGUESS1, iGUESS2, iGUESS3,
    output oREADY, oSCORE_VALID, oRVALUE01, oRVALUE02, oRVALUE03, oRVALUE04,
    output oBlackPegs, oWhitePegs, oNrOfRows, oWIN, oLOSE, oREJECT
  );
endinterface

// File: rtl/mastermind_scorer.sv
// -----------------------------------------------------------------------------
// mastermind_scorer
// Scores Mastermind guesses against a latched secret and tracks game progress
// (rows used, win, lose). Scoring is sequential: 4 BLACK cycles (one per
// position), 6 WHITE cycles (one per colour 1..6), then one DONE cycle that
// publishes the score. Acceptance to score pulse is 11 clocks.
// Ports:
//   iCLK  : rising-edge clock
//   iRST  : synchronous active-high reset
//   bus   : mastermind_scorer_if.slave (game control, guess, score outputs)
// Parameter:
//   MAX_ROWS : guesses allowed per game (1..7)
// Optional feature macro: SCORER_REJECT_INVALID_EN
//   defined   : a guess containing colour 0 or 7 is rejected at the first
//               BLACK cycle with a one-cycle oREJECT pulse, no row consumed
//   undefined : invalid colours simply never match; oREJECT stays 0
// -----------------------------------------------------------------------------
module mastermind_scorer #(
  parameter int unsigned MAX_ROWS = 7
) (
  input logic                iCLK,
  input logic                iRST,
  mastermind_scorer_if.slave bus
);

  localparam logic [2:0] MAX_ROWS_C = 3'(MAX_ROWS);

  typedef enum logic [2:0] {
    S_NOGAME = 3'd0,
    S_IDLE   = 3'd1,
    S_BLACK  = 3'd2,
    S_WHITE  = 3'd3,
    S_DONE   = 3'd4,
    S_OVER   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [3:0][2:0] secret_q, secret_d;
  logic [3:0][2:0] guess_q, guess_d;
  logic [3:0]      match_q, match_d;   // position already consumed by a black peg
  logic [2:0]      step_q, step_d;     // position in BLACK, colour in WHITE
  logic [2:0]      black_q, black_d;
  logic [2:0]      white_q, white_d;
  logic [3:0][2:0] rvalue_q, rvalue_d;
  logic [2:0]      black_pegs_q, black_pegs_d;
  logic [2:0]      white_pegs_q, white_pegs_d;
  logic [2:0]      rows_q, rows_d;
  logic            win_q, win_d;
  logic            lose_q, lose_d;
  logic            ready_q, ready_d;
  logic            score_valid_q, score_valid_d;
  logic            reject_q, reject_d;
  logic            accept_s;
  logic [2:0]      g_cnt_s, s_cnt_s;
`ifdef SCORER_REJECT_INVALID_EN
  logic            invalid_s;
`endif

  // Colours 0 and 7 are outside the game palette.
  function automatic logic colour_ok(input logic [2:0] c);
    return (c != 3'd0) && (c != 3'd7);
  endfunction

  // Number of not-yet-matched positions in codes holding the given colour.
  function automatic logic [2:0] count_unmatched(input logic [3:0][2:0] codes,
                                                 input logic [3:0]      matched,
                                                 input logic [2:0]      colour);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!matched[i] && (codes[i] == colour)) begin
        n = n + 3'd1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Next-state and next-output logic of the scoring FSM.
  always_comb begin
    state_d       = state_q;
    secret_d      = secret_q;
    guess_d       = guess_q;
    match_d       = match_q;
    step_d        = step_q;
    black_d       = black_q;
    white_d       = white_q;
    rvalue_d      = rvalue_q;
    black_pegs_d  = black_pegs_q;
    white_pegs_d  = white_pegs_q;
    rows_d        = rows_q;
    win_d         = win_q;
    lose_d        = lose_q;
    score_valid_d = 1'b0;
    reject_d      = 1'b0;
    accept_s      = (state_q == S_IDLE) && ready_q && bus.iGUESS_VALID;
    // In WHITE, step_q is the colour being counted.
    g_cnt_s       = count_unmatched(guess_q, match_q, step_q);
    s_cnt_s       = count_unmatched(secret_q, match_q, step_q);
`ifdef SCORER_REJECT_INVALID_EN
    invalid_s     = !colour_ok(guess_q[0]) || !colour_ok(guess_q[1]) ||
                    !colour_ok(guess_q[2]) || !colour_ok(guess_q[3]);
`endif

    if (bus.iNEW_GAME) begin
      // A new game overrides everything, including a guess offered this cycle.
      state_d      = S_IDLE;
      secret_d     = {bus.iSECRET3, bus.iSECRET2, bus.iSECRET1, bus.iSECRET0};
      match_d      = 4'b0000;
      step_d       = 3'd0;
      black_d      = 3'd0;
      white_d      = 3'd0;
      rvalue_d     = '0;
      black_pegs_d = 3'd0;
      white_pegs_d = 3'd0;
      rows_d       = 3'd0;
      win_d        = 1'b0;
      lose_d       = 1'b0;
    end else begin
      case (state_q)
        S_NOGAME: state_d = S_NOGAME;
        S_IDLE: begin
          if (accept_s) begin
            guess_d = {bus.iGUESS3, bus.iGUESS2, bus.iGUESS1, bus.iGUESS0};
            match_d = 4'b0000;
            step_d  = 3'd0;
            black_d = 3'd0;
            white_d = 3'd0;
            state_d = S_BLACK;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BLACK: begin
          if (colour_ok(guess_q[step_q[1:0]]) &&
              (guess_q[step_q[1:0]] == secret_q[step_q[1:0]])) begin
            match_d[step_q[1:0]] = 1'b1;
            black_d              = black_q + 3'd1;
          end else begin
            black_d = black_q;
          end
          if (step_q == 3'd3) begin
            step_d  = 3'd1;
            state_d = S_WHITE;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = S_BLACK;
          end
`ifdef SCORER_REJECT_INVALID_EN
          if ((step_q == 3'd0) && invalid_s) begin
            reject_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            reject_d = 1'b0;
          end
`endif
        end
        S_WHITE: begin
          white_d = white_q + ((g_cnt_s < s_cnt_s) ? g_cnt_s : s_cnt_s);
          if (step_q == 3'd6) begin
            state_d = S_DONE;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = S_WHITE;
          end
        end
        S_DONE: begin
          rvalue_d      = guess_q;
          black_pegs_d  = black_q;
          white_pegs_d  = white_q;
          rows_d        = rows_q + 3'd1;
          score_valid_d = 1'b1;
          if (black_q == 3'd4) begin
            win_d   = 1'b1;
            state_d = S_OVER;
          end else if (rows_d == MAX_ROWS_C) begin
            lose_d  = 1'b1;
            state_d = S_OVER;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_OVER:  state_d = S_OVER;
        default: state_d = S_NOGAME;
      endcase
    end

    ready_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q       <= S_NOGAME;
      secret_q      <= '0;
      guess_q       <= '0;
      match_q       <= 4'b0000;
      step_q        <= 3'd0;
      black_q       <= 3'd0;
      white_q       <= 3'd0;
      rvalue_q      <= '0;
      black_pegs_q  <= 3'd0;
      white_pegs_q  <= 3'd0;
      rows_q        <= 3'd0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      ready_q       <= 1'b0;
      score_valid_q <= 1'b0;
      reject_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      secret_q      <= secret_d;
      guess_q       <= guess_d;
      match_q       <= match_d;
      step_q        <= step_d;
      black_q       <= black_d;
      white_q       <= white_d;
      rvalue_q      <= rvalue_d;
      black_pegs_q  <= black_pegs_d;
      white_pegs_q  <= white_pegs_d;
      rows_q        <= rows_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
      ready_q       <= ready_d;
      score_valid_q <= score_valid_d;
      reject_q      <= reject_d;
    end
  end

  assign bus.oREADY       = ready_q;
  assign bus.oSCORE_VALID = score_valid_q;
  assign bus.oRVALUE01    = rvalue_q[0];
  assign bus.oRVALUE02    = rvalue_q[1];
  assign bus.oRVALUE03    = rvalue_q[2];
  assign bus.oRVALUE04    = rvalue_q[3];
  assign bus.oBlackPegs   = black_pegs_q;
  assign bus.oWhitePegs   = white_pegs_q;
  assign bus.oNrOfRows    = rows_q;
  assign bus.oWIN         = win_q;
  assign bus.oLOSE        = lose_q;
  // Without the reject feature reject_d is constant 0, so this stays 0.
  assign bus.oREJECT      = reject_q;

endmodule

// File: tb/tb_mastermind_scorer.sv
module tb_mastermind_scorer;
  localparam int MAX_ROWS = 7;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  int m_secret[4];
  int m_rows;
  bit m_win;
  bit m_lose;

  mastermind_scorer_if bus();

  mastermind_scorer #(.MAX_ROWS(MAX_ROWS)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Black = exact position hits; white = sum over colours of min counts minus black.
  function automatic void ref_score(input int s[4], input int g[4], output int b, output int w);
    int cs[8];
    int cg[8];
    int tot;
    b = 0;
    tot = 0;
    for (int c = 0; c < 8; c++) begin
      cs[c] = 0;
      cg[c] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (g[i] == s[i] && g[i] >= 1 && g[i] <= 6) b++;
      cs[s[i]]++;
      cg[g[i]]++;
    end
    for (int c = 1; c <= 6; c++) tot += (cs[c] < cg[c]) ? cs[c] : cg[c];
    w = tot - b;
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, "_rows"}, 32'(bus.oNrOfRows), 0);
    check({tag, "_black"}, 32'(bus.oBlackPegs), 0);
    check({tag, "_white"}, 32'(bus.oWhitePegs), 0);
    check({tag, "_rval"}, 32'({bus.oRVALUE04, bus.oRVALUE03, bus.oRVALUE02, bus.oRVALUE01}), 0);
    check({tag, "_win"}, 32'(bus.oWIN), 0);
    check({tag, "_lose"}, 32'(bus.oLOSE), 0);
  endtask

  task automatic new_game(input int s0, input int s1, input int s2, input int s3);
    bus.iNEW_GAME = 1'b1;
    bus.iSECRET0 = 3'(s0); bus.iSECRET1 = 3'(s1);
    bus.iSECRET2 = 3'(s2); bus.iSECRET3 = 3'(s3);
    step();
    bus.iNEW_GAME = 1'b0;
    m_secret = '{s0, s1, s2, s3};
    m_rows = 0; m_win = 1'b0; m_lose = 1'b0;
    check("newgame_ready", 32'(bus.oREADY), 1);
    check_cleared("newgame");
  endtask

  // Watch for n cycles: no score pulse may appear and rows must hold.
  task automatic no_pulse_window(input string tag, input int n);
    int pulses = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (bus.oSCORE_VALID === 1'b1) pulses++;
    end
    check({tag, "_pulses"}, 32'(pulses), 0);
    check({tag, "_rows"}, 32'(bus.oNrOfRows), 32'(m_rows));
  endtask

  task automatic play_guess(input int g0, input int g1, input int g2, input int g3);
    int g[4];
    int b, w, n;
    bit rej;
    g = '{g0, g1, g2, g3};
    for (int k = 0; k < 30 && bus.oREADY !== 1'b1; k++) step();
    check("ready_before_guess", 32'(bus.oREADY), 1);
    bus.iGUESS0 = 3'(g0); bus.iGUESS1 = 3'(g1);
    bus.iGUESS2 = 3'(g2); bus.iGUESS3 = 3'(g3);
    bus.iGUESS_VALID = 1'b1;
    step();  // E0
    bus.iGUESS_VALID = 1'b0;
    check("ready_after_accept", 32'(bus.oREADY), 0);
    rej = 1'b0;
`ifdef SCORER_REJECT_INVALID_EN
    for (int i = 0; i < 4; i++) if (g[i] == 0 || g[i] == 7) rej = 1'b1;
`endif
    if (rej) begin
      step();  // E1
      check("reject_pulse", 32'(bus.oREJECT), 1);
      check("reject_ready", 32'(bus.oREADY), 1);
      check("reject_rows", 32'(bus.oNrOfRows), 32'(m_rows));
      check("reject_novalid", 32'(bus.oSCORE_VALID), 0);
      step();
      check("reject_one_cycle", 32'(bus.oREJECT), 0);
    end else begin
      n = 0;
      while (n < 20 && bus.oSCORE_VALID !== 1'b1) begin
        step();
        n++;
      end
      check("latency", 32'(n), 11);
      ref_score(m_secret, g, b, w);
      m_rows++;
      if (b == 4) m_win = 1'b1;
      else if (m_rows == MAX_ROWS) m_lose = 1'b1;
      check("black", 32'(bus.oBlackPegs), 32'(b));
      check("white", 32'(bus.oWhitePegs), 32'(w));
      check("rows", 32'(bus.oNrOfRows), 32'(m_rows));
      check("win", 32'(bus.oWIN), 32'(m_win));
      check("lose", 32'(bus.oLOSE), 32'(m_lose));
      check("rvalue", 32'({bus.oRVALUE04, bus.oRVALUE03, bus.oRVALUE02, bus.oRVALUE01}),
            32'(g3 * 512 + g2 * 64 + g1 * 8 + g0));
      check("reject_idle", 32'(bus.oREJECT), 0);
      step();
      check("valid_one_cycle", 32'(bus.oSCORE_VALID), 0);
      check("ready_after_score", 32'(bus.oREADY), 32'(!(m_win || m_lose)));
      check("black_hold", 32'(bus.oBlackPegs), 32'(b));
    end
  endtask

  initial begin
    int gr[4];
    rst = 1'b1;
    bus.iNEW_GAME = 1'b0; bus.iGUESS_VALID = 1'b0;
    bus.iSECRET0 = 3'd0; bus.iSECRET1 = 3'd0; bus.iSECRET2 = 3'd0; bus.iSECRET3 = 3'd0;
    bus.iGUESS0 = 3'd0; bus.iGUESS1 = 3'd0; bus.iGUESS2 = 3'd0; bus.iGUESS3 = 3'd0;
    m_rows = 0; m_win = 1'b0; m_lose = 1'b0;
    m_secret = '{0, 0, 0, 0};
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_ready", 32'(bus.oREADY), 0);
    check("rst_valid", 32'(bus.oSCORE_VALID), 0);
    check("rst_reject", 32'(bus.oREJECT), 0);
    check_cleared("rst");

    // Guess in NOGAME is ignored
    bus.iGUESS0 = 3'd1; bus.iGUESS1 = 3'd2; bus.iGUESS2 = 3'd3; bus.iGUESS3 = 3'd4;
    bus.iGUESS_VALID = 1'b1;
    repeat (2) step();
    bus.iGUESS_VALID = 1'b0;
    no_pulse_window("nogame", 14);
    check("nogame_ready", 32'(bus.oREADY), 0);

    // Reset overrides new game
    rst = 1'b1; bus.iNEW_GAME = 1'b1;
    step();
    rst = 1'b0; bus.iNEW_GAME = 1'b0;
    check("rst_over_newgame_ready", 32'(bus.oREADY), 0);

    // Winning guess
    new_game(1, 2, 3, 4);
    play_guess(1, 2, 3, 4);
    check("win_flag", 32'(bus.oWIN), 1);
    // OVER ignores guesses
    bus.iGUESS_VALID = 1'b1;
    repeat (3) step();
    bus.iGUESS_VALID = 1'b0;
    no_pulse_window("over", 14);
    check("over_ready", 32'(bus.oREADY), 0);

    // All whites
    new_game(1, 1, 2, 2);
    play_guess(2, 2, 1, 1);
    // One black, no whites
    new_game(1, 2, 3, 4);
    play_guess(1, 1, 1, 1);

    // New game together with guess: guess dropped
    bus.iNEW_GAME = 1'b1;
    bus.iSECRET0 = 3'd3; bus.iSECRET1 = 3'd3; bus.iSECRET2 = 3'd3; bus.iSECRET3 = 3'd3;
    bus.iGUESS0 = 3'd3; bus.iGUESS1 = 3'd3; bus.iGUESS2 = 3'd3; bus.iGUESS3 = 3'd3;
    bus.iGUESS_VALID = 1'b1;
    step();
    bus.iNEW_GAME = 1'b0; bus.iGUESS_VALID = 1'b0;
    m_secret = '{3, 3, 3, 3}; m_rows = 0; m_win = 1'b0; m_lose = 1'b0;
    check("ng_guess_ready", 32'(bus.oREADY), 1);
    no_pulse_window("ng_guess", 14);

    // New game at E5 aborts scoring
    new_game(1, 2, 3, 4);
    play_guess(6, 6, 6, 6);
    bus.iGUESS0 = 3'd5; bus.iGUESS1 = 3'd5; bus.iGUESS2 = 3'd6; bus.iGUESS3 = 3'd6;
    bus.iGUESS_VALID = 1'b1;
    step();  // E0
    bus.iGUESS_VALID = 1'b0;
    repeat (4) @(posedge clk);  // E1..E4
    #1;
    bus.iNEW_GAME = 1'b1;
    bus.iSECRET0 = 3'd5; bus.iSECRET1 = 3'd5; bus.iSECRET2 = 3'd6; bus.iSECRET3 = 3'd6;
    step();  // E5
    bus.iNEW_GAME = 1'b0;
    m_secret = '{5, 5, 6, 6}; m_rows = 0; m_win = 1'b0; m_lose = 1'b0;
    check("abort_ready", 32'(bus.oREADY), 1);
    check("abort_rows", 32'(bus.oNrOfRows), 0);
    no_pulse_window("abort", 14);
    play_guess(5, 5, 6, 6);

    // Invalid colour guess
    new_game(1, 2, 3, 4);
    play_guess(0, 2, 3, 4);
    play_guess(2, 1, 7, 3);

    // Seven non-winning guesses lose the game
    new_game(1, 2, 3, 4);
    for (int r = 0; r < MAX_ROWS; r++) begin
      play_guess(2, 1, 4, 3 + (r % 3));
    end
    check("lose_flag", 32'(bus.oLOSE), 1);
    check("lose_rows", 32'(bus.oNrOfRows), 7);
    bus.iGUESS0 = 3'd1; bus.iGUESS1 = 3'd2; bus.iGUESS2 = 3'd3; bus.iGUESS3 = 3'd4;
    bus.iGUESS_VALID = 1'b1;
    step();
    bus.iGUESS_VALID = 1'b0;
    no_pulse_window("eighth", 14);
    check("eighth_win", 32'(bus.oWIN), 0);

    // Randomised games
    for (int gi = 0; gi < 4; gi++) begin
      new_game(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
               int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
      for (int k = 0; k < 12 && !m_win && !m_lose; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          gr = m_secret;
        end else begin
          for (int i = 0; i < 4; i++) begin
            gr[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                                 : int'($urandom_range(1, 6));
          end
        end
        play_guess(gr[0], gr[1], gr[2], gr[3]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
